// File: rtl/video_pkg.sv
// video_pkg: pattern mode encoding and colour-bar palette shared by the video blocks.
package video_pkg;
  typedef enum logic [1:0] {MODE_BAR, MODE_RAMP, MODE_CHK, MODE_SOLID} mode_e;
  // index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000ff, 24'hff0000, 24'hff00ff,
    24'h00ff00, 24'h00ffff, 24'hffff00, 24'hffffff
  };
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters with combinational sync and data-enable decode.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [15:0] r_h, r_v;
  always_ff @(posedge clk)
    if (rst || !i_en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == 16'(HT - 1)) begin
      r_h <= '0;
      r_v <= (r_v == 16'(VT - 1)) ? '0 : r_v + 16'd1;
    end else
      r_h <= r_h + 16'd1;
  assign o_x  = r_h;
  assign o_y  = r_v;
  assign o_hs = (r_h >= 16'(H_ACTIVE + H_FP) && r_h < 16'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
  assign o_vs = (r_v >= 16'(V_ACTIVE + V_FP) && r_v < 16'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
  assign o_de = r_h < 16'(H_ACTIVE) && r_v < 16'(V_ACTIVE);
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: test-pattern source with one registered stage over the raster timing.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CHK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        frame_start
);
  localparam int BW = H_ACTIVE / 8;
  logic [15:0] w_x, w_y;
  logic        w_hs, w_vs, w_de, w_sof, w_chk;
  logic [2:0]  w_bar;
  logic [23:0] w_solid, w_pix;
  mode_e       w_mode, r_mode;
  logic [23:0] r_solid, r_rgb;
  logic        r_hs, r_vs, r_de, r_fs;
  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .i_en(en),
    .o_x(w_x), .o_y(w_y), .o_hs(w_hs), .o_vs(w_vs), .o_de(w_de)
  );
  assign w_sof = w_x == '0 && w_y == '0;
  // the first pixel of a frame already uses the freshly sampled settings
  assign w_mode  = w_sof ? mode_e'(mode) : r_mode;
  assign w_solid = w_sof ? solid_rgb : r_solid;
  assign w_chk   = w_x[CHK_LOG2] ^ w_y[CHK_LOG2];
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (w_x >= 16'(k * BW)) w_bar = 3'(k);
  end
  assign w_pix = (w_mode == MODE_BAR)  ? BAR_RGB[w_bar] :
                 (w_mode == MODE_RAMP) ? {3{w_x[7:0]}} :
                 (w_mode == MODE_CHK)  ? (w_chk ? 24'h000000 : 24'hffffff) : w_solid;
  always_ff @(posedge clk)
    if (rst) begin
      r_mode  <= MODE_BAR;
      r_solid <= '0;
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else begin
      if (en && w_sof) begin
        r_mode  <= w_mode;
        r_solid <= w_solid;
      end
      r_hs  <= en ? w_hs : ~HS_POL;
      r_vs  <= en ? w_vs : ~VS_POL;
      r_de  <= en && w_de;
      r_rgb <= (en && w_de) ? w_pix : '0;
      r_fs  <= en && w_de && w_sof;
    end
  assign hs = r_hs;
  assign vs = r_vs;
  assign de = r_de;
  assign {rgb_r, rgb_g, rgb_b} = r_rgb;
  assign frame_start = r_fs;
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, horizontal active pixels.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, vertical active lines.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameters HS_POL / VS_POL, default 1 / 1, sync asserted level.
REQ-006 Parameter CHK_LOG2, default 5, checker square size is 2^CHK_LOG2 pixels.
REQ-007 clk  input  1  pixel clock; the only clock.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 en  input  1  run enable.
REQ-010 mode  input  2  pattern select: 0 colour bar, 1 gray ramp, 2 checker, 3 solid.
REQ-011 solid_rgb  input  24  solid colour {R,G,B} for mode 3.
REQ-012 hs, vs, de  output  1 each  sync and data-enable.
REQ-013 rgb_r, rgb_g, rgb_b  output  8 each  pixel data.
REQ-014 frame_start  output  1  one-cycle pulse aligned with first active pixel of a frame.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0; v_cnt SHALL increment on h_cnt wrap and wrap 0 after V_TOTAL-1.
REQ-016 Region order per line SHALL be active [0, H_ACTIVE), FP, SYNC, BP; per frame the same order in lines.
REQ-017 hs SHALL equal HS_POL while h_cnt is in the SYNC region, else ~HS_POL; vs likewise on v_cnt with VS_POL, transitioning at h_cnt==0.
REQ-018 de SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-019 All outputs SHALL be registered with exactly one clk latency from counter state; hs, vs, de, rgb, frame_start mutually aligned.
REQ-020 rgb SHALL be 0 whenever de is 0.
REQ-021 mode and solid_rgb SHALL be sampled only at h_cnt==0 and v_cnt==0; mid-frame changes take effect next frame.
REQ-022 Mode 0: x in [k*(H_ACTIVE/8), (k+1)*(H_ACTIVE/8)) gives bar k, order white, yellow, cyan, green, magenta, red, blue, black; bar 7 absorbs the H_ACTIVE%8 remainder.
REQ-023 Mode 1: R=G=B=x[7:0], wrapping every 256 pixels.
REQ-024 Mode 2: white when x[CHK_LOG2] XOR y[CHK_LOG2] is 0, else black.
REQ-025 Mode 3: output the latched solid_rgb.
REQ-026 No divider SHALL be used; bar boundaries are elaboration-time constants.
REQ-027 en=0 SHALL hold counters at 0 and drive idle outputs (sync inactive, de=0, rgb=0); the first cycle with en=1 starts a frame at h_cnt=v_cnt=0.
REQ-028 en dropping mid-frame SHALL abort the frame immediately, counters return to 0.
REQ-029 frame_start SHALL pulse with the de of x=0, y=0 only.

Reset
REQ-030 rst=1 SHALL force h_cnt=v_cnt=0, latched mode=0, latched solid=0, hs=~HS_POL, vs=~VS_POL, de=0, rgb=0, frame_start=0 on the next clk edge; rst has priority over en.

Structure
REQ-031 Colour constants (8 bar colours) and the mode encoding SHALL live in a shared package video_pkg.
REQ-032 Timing counters and sync/de generation SHALL be a sub-module video_timing_gen; the top adds the pattern pipeline stage.

Verification
REQ-033 Small timing (H 16/2/3/2, V 8/1/2/1), mode 0, en=1 -> de high 16 cycles per line for 8 lines, bar width 2, hs high 3 cycles, H_TOTAL 23, V_TOTAL 12.
REQ-034 H_ACTIVE=20 mode 0 -> bars 0..6 are 2 px, bar 7 is 6 px black.
REQ-035 mode changes 0->2 at mid-frame -> current frame stays bars; next frame checker, CHK_LOG2=1 gives alternating 2x2 squares.
REQ-036 mode 3, solid_rgb=24'h12_34_56 -> every de pixel 12/34/56, blanking 00/00/00.
REQ-037 rst pulsed mid-line, then en dropped for 5 cycles -> outputs idle within 1 cycle; frame_start next pulses exactly H_TOTAL*0+1 cycle after restart (first active pixel).
REQ-038 HS_POL=0, VS_POL=0 -> sync idle high, low only in SYNC regions; default params -> 800x525 frame, 420000 cycles between frame_start pulses.
